// File: rtl/seg7_scan_driver.sv
// Multi-digit seven-segment scanner with tear-free frame commit.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to auto-blank leading zeros.
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int DIV_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic                  ready,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW    = 4 * DIGITS;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  logic [DIV_BITS-1:0] r_div;
  logic [IDX_W-1:0]    r_idx;
  logic [VW-1:0]       r_disp;
  logic [VW-1:0]       r_pend;
  logic                r_pending;
  logic                r_bnd;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_sel;
  logic                r_tick;

  logic                w_step;
  logic                w_bnd;
  logic                w_acc;
  logic [3:0]          w_nib;
  logic                w_blank;
  logic [DIGITS-1:0]   w_onehot;
  logic [DIGITS-1:0]   w_lz;
  logic [DIGITS-1:0]   w_blank_vec;
  logic [6:0]          w_seg;

  function automatic logic [6:0] f_dec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_step = &r_div;
  assign w_bnd  = w_step && (r_idx == LAST);
  assign w_acc  = load && !r_pending;

  // Digit i>0 is a leading zero when it and every higher nibble are zero.
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    w_lz    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero = hi_zero && (r_disp[4*i +: 4] == 4'h0);
      w_lz[i] = hi_zero;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign w_blank_vec = blank_mask | w_lz;
`else
  assign w_blank_vec = blank_mask;
`endif

  always_comb begin
    w_nib    = 4'h0;
    w_blank  = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_disp[4*i +: 4];
        w_blank     = w_blank_vec[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_seg = w_blank ? 7'h00 : f_dec(w_nib);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= '0;
      r_idx     <= '0;
      r_disp    <= '0;
      r_pend    <= '0;
      r_pending <= 1'b0;
      r_bnd     <= 1'b0;
      r_seg     <= 7'h00;
      r_sel     <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_div <= r_div + DIV_BITS'(1);
      if (w_step) begin
        r_idx <= (r_idx == LAST) ? '0 : r_idx + IDX_W'(1);
      end
      // A load accepted in the boundary cycle sees pending=0 here,
      // so it waits a whole frame for its commit.
      if (w_bnd && r_pending) begin
        r_disp    <= r_pend;
        r_pending <= 1'b0;
      end
      if (w_acc) begin
        r_pend    <= value;
        r_pending <= 1'b1;
      end
      r_bnd  <= w_bnd;
      r_seg  <= w_seg;
      r_sel  <= w_onehot;
      r_tick <= r_bnd;
    end
  end

  assign ready      = !r_pending;
  assign segments   = r_seg;
  assign digit_sel  = r_sel;
  assign frame_tick = r_tick;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multi-digit seven-segment scanner for the TinyTapeout-style output path: it latches a packed hex value and time-multiplexes it across `DIGITS` common-cathode digits. Frames are tear-free: a new value is committed only at a frame boundary, under a load/ready handshake. It sits between the core logic and `io_out`, generalising the single fixed 7-segment output to N digits with per-digit blanking.

## Interface
- `DIGITS`, 4: number of digits scanned; ≥1.
- `DIV_BITS`, 10: width of the scan prescaler; each digit is lit for 2^DIV_BITS cycles.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `load`  in  1  request to capture `value`; accepted only when `ready`=1.
- `value`  in  4*DIGITS  packed hex nibbles; nibble i = `value[4i+3:4i]` drives digit i; digit DIGITS-1 is most significant.
- `blank_mask`  in  DIGITS  bit i=1 forces digit i dark; applied live, not shadowed.
- `ready`  out  1  high when no commit is pending.
- `segments`  out  7  segment drive, active-high, bit0=a … bit6=g.
- `digit_sel`  out  DIGITS  one-hot digit enable, active-high.
- `frame_tick`  out  1  one-cycle pulse at each frame boundary.

## Operation
- State: prescaler `div` (DIV_BITS), digit index `idx` (0..DIGITS-1), display register `disp`, pending register `pend`, flag `pending`.
- Prescaler increments every cycle and wraps 2^DIV_BITS-1→0. A wrap is a `step`.
- On `step`: `idx` advances. It wraps DIGITS-1→0, and that wrap is the frame boundary.
- Handshake: `load`&&`ready` captures `value` into `pend` and sets `pending`. `ready` = !`pending`. `load` while `ready`=0 is ignored; `pend` is unchanged.
- Commit: at a frame boundary with `pending`=1, `disp`←`pend` and `pending` clears.
- Load accepted in the same cycle as a boundary: it is not committed at that boundary. It waits for the next one.
- Decode of nibble `disp[idx]`: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71 (hex).
- Blank: when the digit is blanked, `segments`=00 and `digit_sel` is still the one-hot of `idx`.
- DIGITS=1: `idx` stays 0 and every `step` is a frame boundary.

## Timing
- Reset values: `div`=0, `idx`=0, `disp`=0, `pend`=0, `pending`=0.
- Output reset values: `ready`=1, `segments`=00, `digit_sel`=0, `frame_tick`=0.
- `segments`, `digit_sel` and `frame_tick` are registered: they reflect `idx`/`disp`/`blank_mask` of the previous cycle (latency 1).
- First cycle after reset release: outputs show digit 0 of `disp`=0, i.e. `segments`=3F, `digit_sel`=…0001.
- Frame period: DIGITS·2^DIV_BITS cycles.
- `frame_tick` is high in the cycle after the boundary edge, coincident with `digit_sel` returning to bit 0.
- `ready` falls on the edge after acceptance. It rises on the edge that commits (same edge as `disp` update).
- Worst-case load-to-display latency: one full frame plus 1 cycle.
- `rst` mid-frame or mid-pending clears everything immediately; the pending value is lost.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN` defined: digit i>0 is blanked when `disp` nibbles i..DIGITS-1 are all zero. Digit 0 is never auto-blanked. This is ORed with `blank_mask`.
- Undefined: only `blank_mask` blanks and all zeros are displayed.

## Test plan
Bench uses DIGITS=4, DIV_BITS=2 (16-cycle frame).
- Reset, then run 16 cycles → `digit_sel` cycles 0001,0010,0100,1000 for 4 cycles each; `segments`=3F throughout; `ready`=1; one `frame_tick` per 16 cycles.
- Pulse `load` with `value`=0x1234 mid-frame → `ready`=0 next cycle. At next boundary `disp`=1234 and `ready`=1. The following frame shows 4→66, 3→4F, 2→5B, 1→06 on digits 0..3.
- Hold `load` high with 0xABCD while `ready`=0 after 0x1234 was accepted → ignored; 1234 is displayed; a new 0xABCD is accepted only once `ready` returns.
- Assert `load` exactly in the boundary cycle → commit occurs one frame later, not at that boundary.
- `blank_mask`=0101 with `disp`=8888 → digits 0 and 2 show `segments`=00 and digits 1 and 3 show 7F. Repeat with and without `SEG7_LEADING_ZERO_BLANK_EN`, `disp`=0x0070: with it, digits 3 and 2 are dark; without it they show 3F.
- Assert `rst` while `pending`=1 mid-frame → all outputs reach their reset values asynchronously; after release, digit 0 shows 3F and `ready`=1.
